dreg_pipe: RTL and testbench

- Parametrised successor to the fixed 4-bit D register used to stage CLA adder operands and results.
- WIDTH-bit data passes through DEPTH register stages. Each stage carries a valid bit.
- Valid/ready handshake at both ends: backpressure and bubble collapsing.
- Adds synchronous flush and an occupancy count.
- Sits between operand sources, the CLA adder core and result consumers as the standard pipeline register.

---
 rtl/dreg_pkg.sv | 17 +
 rtl/dreg_pipe_if.sv | 22 ++
 rtl/dreg_stage.sv | 37 +++
 rtl/dreg_pipe.sv | 85 ++++++++
 tb/tb_dreg_pipe.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dreg_pkg.sv
// Shared definitions for the dreg_pipe pipeline register: count-width helper
// and the default value loaded into stage data on reset and flush.
package dreg_pkg;

    localparam int unsigned DEFAULT_RESET_VAL = 0;

    // Smallest w with 2**w >= value, never below 1 so a count port always exists.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dreg_pipe_if.sv
// Valid/ready handshake bundle for dreg_pipe: upstream push side and
// downstream pop side grouped together.
interface dreg_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dreg_stage.sv
// One pipeline stage: valid bit plus data register with load enable.
// Data only updates when a valid item is loaded, so empty stages keep their last value.
module dreg_stage
    import dreg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // NOTE: non-blocking assignments keep every stage sampling the pre-edge
    // value of its neighbour, which is what makes the chain shift by one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/dreg_pipe.sv
// Parametrised pipeline register: DEPTH valid/data stages with a combinational
// ready chain (bubble collapsing), synchronous flush and an occupancy count.
module dreg_pipe
    import dreg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEFAULT_RESET_VAL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    dreg_pipe_if.slave                 bus,
    output logic [clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_v;
    logic [DEPTH-1:0] w_rdy;
    logic [WIDTH-1:0] w_d [DEPTH];
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    r_count;

    // A stage may load if it is empty or everything downstream of it can move.
    always_comb begin : ready_chain
        logic w_chain;
        // NOTE: blocking assignments with a default first: the chain value
        // ripples within one evaluation and no bit is left unassigned (no latch).
        w_rdy   = '0;
        w_chain = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_chain  = ~w_v[i] | w_chain;
            w_rdy[i] = w_chain;
        end
    end

    assign w_in_ready    = w_rdy[0] & ~flush & ~rst;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_v[DEPTH-1] & ~flush & ~rst;
    assign bus.out_data  = rst ? RESET_VAL : w_d[DEPTH-1];

    assign w_push = bus.in_valid & w_in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_vin;
        logic [WIDTH-1:0] w_din;

        if (i == 0) begin : g_head
            assign w_vin = w_push;
            assign w_din = bus.in_data;
        end else begin : g_body
            assign w_vin = w_v[i-1];
            assign w_din = w_d[i-1];
        end

        dreg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .i_load  (w_rdy[i]),
            .i_valid (w_vin),
            .i_data  (w_din),
            .o_valid (w_v[i]),
            .o_data  (w_d[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign count = r_count;
endmodule

// File: tb/tb_dreg_pipe.sv
// Self-checking bench for dreg_pipe: directed vector table (4x2), bubble-collapse
// sequence (4x3) and randomized traffic on 16x1 and 32x5 against a positional model.
module tb_dreg_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_a = 1'b0, flush_b = 1'b0, flush_16 = 1'b0, flush_32 = 1'b0;
    logic [1:0] cnt_a, cnt_b;
    logic       cnt_16;
    logic [2:0] cnt_32;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dreg_pipe_if #(.WIDTH(4))  bus_a ();
    dreg_pipe_if #(.WIDTH(4))  bus_b ();
    dreg_pipe_if #(.WIDTH(16)) bus16 ();
    dreg_pipe_if #(.WIDTH(32)) bus32 ();

    dreg_pipe #(.WIDTH(4), .DEPTH(2)) u_a (
        .clk(clk), .rst(rst), .flush(flush_a), .bus(bus_a.slave), .count(cnt_a));
    dreg_pipe #(.WIDTH(4), .DEPTH(3)) u_b (
        .clk(clk), .rst(rst), .flush(flush_b), .bus(bus_b.slave), .count(cnt_b));
    dreg_pipe #(.WIDTH(16), .DEPTH(1)) u_16 (
        .clk(clk), .rst(rst), .flush(flush_16), .bus(bus16.slave), .count(cnt_16));
    dreg_pipe #(.WIDTH(32), .DEPTH(5)) u_32 (
        .clk(clk), .rst(rst), .flush(flush_32), .bus(bus32.slave), .count(cnt_32));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table (DUT a: WIDTH=4, DEPTH=2) ----------------
    typedef struct {
        bit         rst;
        bit         fl;
        bit         iv;
        logic [3:0] d;
        bit         orr;
        bit         e_ir;
        bit         e_ov;
        bit         chk_d;
        logic [3:0] e_od;
        bit         chk_c;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input bit r, input bit fl, input bit iv, input logic [3:0] d,
                           input bit orr, input bit e_ir, input bit e_ov, input bit chk_d,
                           input logic [3:0] e_od, input bit chk_c, input logic [1:0] e_cnt);
        vec_t v;
        v = '{r, fl, iv, d, orr, e_ir, e_ov, chk_d, e_od, chk_c, e_cnt};
        vq.push_back(v);
    endtask

    task automatic fill_table();
        //      rst fl iv d     or  ir ov cd od    cc cnt
        add_vec(1, 0, 1, 4'hF, 1,  0, 0, 1, 4'h0, 1, 0);  // reset, input ignored
        add_vec(0, 0, 1, 4'h1, 1,  1, 0, 1, 4'h0, 1, 0);  // stream 1,2,3
        add_vec(0, 0, 1, 4'h2, 1,  1, 0, 0, 4'h0, 1, 1);
        add_vec(0, 0, 1, 4'h3, 1,  1, 1, 1, 4'h1, 1, 2);
        add_vec(0, 0, 0, 4'h0, 1,  1, 1, 1, 4'h2, 1, 2);
        add_vec(0, 0, 0, 4'h0, 1,  1, 1, 1, 4'h3, 1, 1);
        add_vec(0, 0, 0, 4'h0, 1,  1, 0, 1, 4'h3, 1, 0);  // empty keeps last value
        add_vec(0, 0, 1, 4'hA, 0,  1, 0, 0, 4'h0, 1, 0);  // backpressure fill
        add_vec(0, 0, 1, 4'hB, 0,  1, 0, 0, 4'h0, 1, 1);
        for (int k = 0; k < 5; k++)
            add_vec(0, 0, 1, 4'hC, 0,  0, 1, 1, 4'hA, 1, 2);
        add_vec(0, 0, 1, 4'hC, 1,  1, 1, 1, 4'hA, 1, 2);  // push+pop when full
        add_vec(0, 0, 0, 4'h0, 1,  1, 1, 1, 4'hB, 1, 2);
        add_vec(0, 0, 0, 4'h0, 1,  1, 1, 1, 4'hC, 1, 1);
        add_vec(0, 0, 1, 4'h7, 0,  1, 0, 0, 4'h0, 1, 0);  // flush scenario
        add_vec(0, 0, 1, 4'h8, 0,  1, 0, 0, 4'h0, 1, 1);
        add_vec(0, 1, 1, 4'h9, 1,  0, 0, 0, 4'h0, 1, 2);
        add_vec(0, 0, 0, 4'h0, 1,  1, 0, 1, 4'h0, 1, 0);
        add_vec(0, 0, 0, 4'h0, 1,  1, 0, 1, 4'h0, 1, 0);
        add_vec(0, 0, 1, 4'h5, 0,  1, 0, 0, 4'h0, 1, 0);  // reset mid-transfer
        add_vec(0, 0, 1, 4'h6, 0,  1, 0, 0, 4'h0, 1, 1);
        add_vec(1, 0, 1, 4'h4, 1,  0, 0, 1, 4'h0, 0, 0);
        add_vec(0, 0, 0, 4'h0, 1,  1, 0, 1, 4'h0, 1, 0);
    endtask

    // ---------------- hand-written bubble sequence (DUT b: DEPTH=3) ----------------
    task automatic step_b(input string name, input bit iv, input logic [3:0] d, input bit orr,
                          input bit e_ir, input bit e_ov, input logic [3:0] e_od,
                          input logic [1:0] e_cnt);
        @(negedge clk);
        bus_b.in_valid  = iv;
        bus_b.in_data   = d;
        bus_b.out_ready = orr;
        #1;
        check({name, ".in_ready"},  64'(bus_b.in_ready),  64'(e_ir));
        check({name, ".out_valid"}, 64'(bus_b.out_valid), 64'(e_ov));
        check({name, ".count"},     64'(cnt_b),           64'(e_cnt));
        if (e_ov) check({name, ".out_data"}, 64'(bus_b.out_data), 64'(e_od));
    endtask

    // ---------------- random traffic vs positional reference model ----------------
    // Model: ordered list of in-flight items, each with its stage position.
    int          m_n[2];
    int          m_pos[2][8];
    logic [31:0] m_dat[2][8];
    bit          s_iv[2], s_or[2], s_fl[2];
    logic [31:0] s_d[2];

    task automatic rand_drive(input int id);
        s_iv[id] = ($urandom_range(0, 3) != 0);
        s_or[id] = ($urandom_range(0, 2) != 0);
        s_fl[id] = ($urandom_range(0, 39) == 0);
        s_d[id]  = $urandom;
        if (id == 0) begin
            s_d[id][31:16]  = '0;
            bus16.in_valid  = s_iv[id];
            bus16.in_data   = s_d[id][15:0];
            bus16.out_ready = s_or[id];
            flush_16        = s_fl[id];
        end else begin
            bus32.in_valid  = s_iv[id];
            bus32.in_data   = s_d[id];
            bus32.out_ready = s_or[id];
            flush_32        = s_fl[id];
        end
    endtask

    task automatic rand_check(input int id, input int cyc);
        int          depth, n, nn;
        bit [7:0]    mv;
        bit          e_ir, e_ov, a_ir, a_ov;
        logic [31:0] a_od;
        int          a_cnt;
        int          npos[8];
        logic [31:0] ndat[8];
        string       tag;

        depth = (id == 0) ? 1 : 5;
        n     = m_n[id];
        mv    = '0;
        // An item moves if it is the oldest (and not stuck at the output) or
        // the slot ahead of it is free or being vacated this cycle.
        for (int k = 0; k < n; k++) begin
            if (k == 0)
                mv[k] = (m_pos[id][0] == depth - 1) ? s_or[id] : 1'b1;
            else
                mv[k] = (m_pos[id][k-1] > m_pos[id][k] + 1) || mv[k-1];
        end
        e_ov = !s_fl[id] && (n > 0) && (m_pos[id][0] == depth - 1);
        e_ir = 1'b0;
        if (!s_fl[id]) begin
            if (n == 0)                    e_ir = 1'b1;
            else if (m_pos[id][n-1] > 0)   e_ir = 1'b1;
            else if (mv[n-1])              e_ir = 1'b1;
        end

        if (id == 0) begin
            a_ir = bus16.in_ready; a_ov = bus16.out_valid;
            a_od = {16'h0, bus16.out_data}; a_cnt = int'(cnt_16);
        end else begin
            a_ir = bus32.in_ready; a_ov = bus32.out_valid;
            a_od = bus32.out_data; a_cnt = int'(cnt_32);
        end
        tag = $sformatf("rand%0d.c%0d", id, cyc);
        check({tag, ".in_ready"},  64'(a_ir),  64'(e_ir));
        check({tag, ".out_valid"}, 64'(a_ov),  64'(e_ov));
        check({tag, ".count"},     64'(a_cnt), 64'(n));
        if (e_ov) check({tag, ".out_data"}, 64'(a_od), 64'(m_dat[id][0]));

        nn = 0;
        if (!s_fl[id]) begin
            for (int k = 0; k < n; k++) begin
                if (!(mv[k] && m_pos[id][k] == depth - 1)) begin
                    npos[nn] = m_pos[id][k] + (mv[k] ? 1 : 0);
                    ndat[nn] = m_dat[id][k];
                    nn++;
                end
            end
            if (s_iv[id] && e_ir) begin
                npos[nn] = 0;
                ndat[nn] = s_d[id];
                nn++;
            end
        end
        for (int k = 0; k < nn; k++) begin
            m_pos[id][k] = npos[k];
            m_dat[id][k] = ndat[k];
        end
        m_n[id] = nn;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_data = '0; bus32.out_ready = 1'b0;
        m_n[0] = 0;
        m_n[1] = 0;
        rst = 1'b1;
        @(posedge clk);

        fill_table();
        foreach (vq[i]) begin
            @(negedge clk);
            rst             = vq[i].rst;
            flush_a         = vq[i].fl;
            bus_a.in_valid  = vq[i].iv;
            bus_a.in_data   = vq[i].d;
            bus_a.out_ready = vq[i].orr;
            #1;
            check($sformatf("vec%0d.in_ready", i),  64'(bus_a.in_ready),  64'(vq[i].e_ir));
            check($sformatf("vec%0d.out_valid", i), 64'(bus_a.out_valid), 64'(vq[i].e_ov));
            if (vq[i].chk_d)
                check($sformatf("vec%0d.out_data", i), 64'(bus_a.out_data), 64'(vq[i].e_od));
            if (vq[i].chk_c)
                check($sformatf("vec%0d.count", i), 64'(cnt_a), 64'(vq[i].e_cnt));
        end
        @(negedge clk);
        rst = 1'b0; flush_a = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;

        //     name    iv d     or ir ov od    cnt
        step_b("bub0",  1, 4'h5, 0, 1, 0, 4'h0, 0);
        step_b("bub1",  0, 4'h0, 0, 1, 0, 4'h0, 1);
        step_b("bub2",  0, 4'h0, 0, 1, 0, 4'h0, 1);
        step_b("bub3",  1, 4'h6, 0, 1, 1, 4'h5, 1);
        step_b("bub4",  0, 4'h0, 0, 1, 1, 4'h5, 2);
        step_b("bub5",  1, 4'h7, 0, 1, 1, 4'h5, 2);
        step_b("bub6",  1, 4'h8, 0, 0, 1, 4'h5, 3);
        step_b("bub7",  0, 4'h0, 1, 1, 1, 4'h5, 3);
        step_b("bub8",  0, 4'h0, 1, 1, 1, 4'h6, 2);
        step_b("bub9",  0, 4'h0, 1, 1, 1, 4'h7, 1);
        step_b("bub10", 0, 4'h0, 1, 1, 0, 4'h0, 0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rand_drive(0);
            rand_drive(1);
            #1;
            rand_check(0, cyc);
            rand_check(1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
